mm_access_unit: RTL and testbench
=================================

Name: mm_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline latch outputs.
- Turns the latched dRENi/dWENi/datomic/ALUOut/store into a dcache request handshake and raises a stall while the request is outstanding.
- Holds the completed result until the pipeline advances, so a request is never re-issued.
- Owns the LL/SC link register and a sticky halt flag.

Parameters:
- CNT_W, 16, width of the saturating memory-stall cycle counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- en  input  1  pipeline advance; the EX/MEM latch loads a new op at this edge.
- flush  input  1  the current MEM-stage op is squashed.
- dRENi  input  1  latched load.
- dWENi  input  1  latched store.
- datomic  input  1  latched LL (with dRENi) or SC (with dWENi).
- halt  input  1  latched halt.
- ALUOut  input  32  latched effective address.
- store  input  32  latched store data.
- dhit  input  1  dcache request done this cycle.
- dmemload  input  32  dcache read data, valid with dhit.
- dmemREN  output  1  dcache read request.
- dmemWEN  output  1  dcache write request.
- dmemaddr  output  32  request address, equals ALUOut.
- dmemstore  output  32  write data, equals store.
- snoop_inv  input  1  coherence invalidate or remote write, this cycle.
- snoop_addr  input  32  address for snoop_inv.
- mm_stall  output  1  MEM stage is waiting on the dcache.
- mm_load  output  32  load data, or SC result (1 success, 0 fail).
- mm_halt  output  1  sticky halt.
- stall_cycles  output  CNT_W  count of cycles with mm_stall high, saturating.

Behaviour:
- State register: ACTIVE (access not yet done), DONE (result held, waiting for en), HALTED.
- Reset values: state ACTIVE, link_valid 0, link_addr 0, load_q 0, stall_cycles 0, mm_halt 0.
- While RST is high, dmemREN, dmemWEN and mm_stall are 0.
- access = (dRENi | dWENi) & !flush.
- sc = dWENi & datomic.
- ll = dRENi & datomic.
- link_ok = link_valid & (link_addr == ALUOut[31:2]).
- sc_fail = sc & !link_ok, using the registered link.
- Requests are combinational; an access that hits in its first cycle has zero added latency.
  - dmemREN = (state == ACTIVE) & access & dRENi.
  - dmemWEN = (state == ACTIVE) & access & dWENi & !sc_fail.
- mm_stall = (state == ACTIVE) & access & !sc_fail & !dhit.
- complete = (state == ACTIVE) & access & (dhit | sc_fail).
- mm_load:
  - In DONE: load_q.
  - Otherwise, for sc: {31'b0, !sc_fail}.
  - Otherwise: dmemload.
- ACTIVE -> DONE on complete & !en; load_q captures mm_load at that edge.
- DONE -> ACTIVE on en.
- complete & en in the same cycle: remain ACTIVE, no capture.
- en while mm_stall = 1 is a protocol violation (hazard unit contract). Bench asserts it never happens. RTL gives en priority and drops the request.
- ACTIVE or DONE -> HALTED on halt & !flush & en, or on halt & !access.
- HALTED is absorbing until RST. In HALTED: mm_halt = 1, no requests, mm_stall = 0.
- Link register updates, priority highest first:
  1. snoop_inv with snoop_addr[31:2] == link_addr clears link_valid, even in the same cycle as a completing LL to that address; the link ends invalid.
  2. A completing SC clears link_valid, success or fail.
  3. A completing non-atomic store with ALUOut[31:2] == link_addr clears link_valid.
  4. A completing LL sets link_valid = 1 and link_addr = ALUOut[31:2].
- A successful SC concurrent with a matching snoop still succeeds, because the decision uses the registered link.
- stall_cycles increments at each edge where mm_stall = 1 and holds at all-ones.
- Reset mid-access: state returns to ACTIVE and the link is lost. The cache side is responsible for abandoning the in-flight request.
- flush while DONE: no effect on state; the following en returns to ACTIVE.

Decomposition:
- cpu_types_pkg: mm_state_t enum {ACTIVE, DONE, HALTED} and link_t struct {valid, word address [29:0]}.
- Sub-module llsc_link_reg: link storage, priority update and link_ok compare. This keeps the FSM/counter top small and lets the link be verified alone.

Test Plan:
- Load to 0x100, dhit after 3 cycles, en held 0 -> dmemREN high 3 cycles, mm_stall high 2 cycles, stall_cycles = 2, state DONE; mm_load = 0xDEADBEEF held with dmemREN = 0 until en, then ACTIVE.
- LL 0x200 hits, then SC 0x200 store = 5 -> dmemWEN = 1, mm_load = 1, link_valid = 0 afterwards.
- LL 0x200, snoop_inv to 0x200 (and separately to 0x204), then SC 0x200 -> for 0x200: dmemWEN = 0, mm_load = 0, mm_stall = 0 in the same cycle; for 0x204: SC succeeds.
- LL completing in the same cycle as snoop_inv to 0x300 -> link_valid = 0; a following SC 0x300 fails.
- Halt with no access, en = 1 -> mm_halt = 1 next cycle; later dRENi = 1 -> dmemREN stays 0; RST clears mm_halt.
- 70000 consecutive stall cycles with CNT_W = 16 -> stall_cycles saturates at 0xFFFF. RST asserted mid-stall -> stall_cycles 0 and dmemREN 0 immediately (asynchronous).

Source files
------------

// File: rtl/mm_access_unit_pkg.sv
// Shared types for the memory-stage access unit: FSM state encoding and the
// LL/SC link record.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      DONE   = 2'd1,
      HALTED = 2'd2
   } mm_state_t;

   typedef struct packed {
      logic        valid;
      logic [29:0] waddr;
   } link_t;

endpackage

// File: rtl/mm_access_unit_if.sv
// EX/MEM latch, dcache handshake, snoop and status signals of the memory stage.
// The slave modport is the access unit; the master side is its environment.
interface mm_access_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             flush;
   logic             dRENi;
   logic             dWENi;
   logic             datomic;
   logic             halt;
   logic [31:0]      ALUOut;
   logic [31:0]      store;
   logic             dhit;
   logic [31:0]      dmemload;
   logic             dmemREN;
   logic             dmemWEN;
   logic [31:0]      dmemaddr;
   logic [31:0]      dmemstore;
   logic             snoop_inv;
   logic [31:0]      snoop_addr;
   logic             mm_stall;
   logic [31:0]      mm_load;
   logic             mm_halt;
   logic [CNT_W-1:0] stall_cycles;

   modport slave (
      input  en, flush, dRENi, dWENi, datomic, halt, ALUOut, store,
             dhit, dmemload, snoop_inv, snoop_addr,
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
             mm_stall, mm_load, mm_halt, stall_cycles
   );

   modport master (
      output en, flush, dRENi, dWENi, datomic, halt, ALUOut, store,
             dhit, dmemload, snoop_inv, snoop_addr,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
             mm_stall, mm_load, mm_halt, stall_cycles
   );
endinterface

// File: rtl/mm_access_unit_link.sv
// LL/SC link register: holds the reserved word address, applies the
// snoop/SC/store/LL update priority and reports whether an SC may succeed.
module llsc_link_reg
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_complete,
   input  logic        i_ll,
   input  logic        i_sc,
   input  logic        i_plain_store,
   input  logic [29:0] i_waddr,
   input  logic        i_snoop_inv,
   input  logic [29:0] i_snoop_waddr,
   output logic        o_link_ok
);

   link_t r_link;
   link_t w_link_next;
   logic  w_ll_done;
   logic  w_sc_done;
   logic  w_st_done;
   logic  w_snoop_hit;

   assign w_ll_done = i_complete & i_ll;
   assign w_sc_done = i_complete & i_sc;
   assign w_st_done = i_complete & i_plain_store & (i_waddr == r_link.waddr);

   // A snoop also kills a reservation being created this very cycle.
   assign w_snoop_hit = i_snoop_inv &
                        ((i_snoop_waddr == r_link.waddr) |
                         (w_ll_done & (i_snoop_waddr == i_waddr)));

   assign o_link_ok = r_link.valid & (r_link.waddr == i_waddr);

   // Lowest priority first so later statements override earlier ones.
   always_comb begin
      w_link_next = r_link;
      if (w_ll_done) begin
         w_link_next.valid = 1'b1;
         w_link_next.waddr = i_waddr;
      end
      if (w_st_done)   w_link_next.valid = 1'b0;
      if (w_sc_done)   w_link_next.valid = 1'b0;
      if (w_snoop_hit) w_link_next.valid = 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_link <= '0;
      end else begin
         r_link <= w_link_next;
      end
   end

endmodule

// File: rtl/mm_access_unit.sv
// Memory-stage access unit: issues dcache requests from the EX/MEM latch,
// stalls until done, holds the result until the pipeline advances.
module mm_access_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic           CLK,
   input  logic           RST,
   mm_access_if.slave     bus
);

   mm_state_t        r_state;
   mm_state_t        w_state_next;
   logic [31:0]      r_load_q;
   logic [CNT_W-1:0] r_stall_cnt;

   logic        w_access;
   logic        w_sc;
   logic        w_ll;
   logic        w_link_ok;
   logic        w_sc_fail;
   logic        w_ren;
   logic        w_wen;
   logic        w_stall;
   logic        w_complete;
   logic [31:0] w_load;
   logic        w_unused_bits;

   assign w_access  = (bus.dRENi | bus.dWENi) & ~bus.flush;
   assign w_sc      = bus.dWENi & bus.datomic;
   assign w_ll      = bus.dRENi & bus.datomic;
   assign w_sc_fail = w_sc & ~w_link_ok;

   assign w_unused_bits = ^{bus.ALUOut[1:0], bus.snoop_addr[1:0]};

   llsc_link_reg u_link (
      .CLK           (CLK),
      .RST           (RST),
      .i_complete    (w_complete),
      .i_ll          (w_ll),
      .i_sc          (w_sc),
      .i_plain_store (bus.dWENi & ~bus.datomic),
      .i_waddr       (bus.ALUOut[31:2]),
      .i_snoop_inv   (bus.snoop_inv),
      .i_snoop_waddr (bus.snoop_addr[31:2]),
      .o_link_ok     (w_link_ok)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ACTIVE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; en wins over a pending request, which is then dropped.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACTIVE: begin
            if (bus.halt & ((~bus.flush & bus.en) | ~w_access)) begin
               w_state_next = HALTED;
            end else if (w_complete & ~bus.en) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (bus.halt & ((~bus.flush & bus.en) | ~w_access)) begin
               w_state_next = HALTED;
            end else if (bus.en) begin
               w_state_next = ACTIVE;
            end
         end
         default: w_state_next = HALTED;
      endcase
   end

   // Output logic
   always_comb begin
      w_ren      = 1'b0;
      w_wen      = 1'b0;
      w_stall    = 1'b0;
      w_complete = 1'b0;
      w_load     = w_sc ? {31'b0, ~w_sc_fail} : bus.dmemload;
      case (r_state)
         ACTIVE: begin
            w_ren      = w_access & bus.dRENi;
            w_wen      = w_access & bus.dWENi & ~w_sc_fail;
            w_stall    = w_access & ~w_sc_fail & ~bus.dhit;
            w_complete = w_access & (bus.dhit | w_sc_fail);
         end
         DONE:    w_load = r_load_q;
         default: ;
      endcase
      if (RST) begin
         w_ren   = 1'b0;
         w_wen   = 1'b0;
         w_stall = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_load_q <= 32'h0;
      end else if ((r_state == ACTIVE) && (w_state_next == DONE)) begin
         r_load_q <= w_load;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.dmemREN      = w_ren;
   assign bus.dmemWEN      = w_wen;
   assign bus.dmemaddr     = bus.ALUOut;
   assign bus.dmemstore    = bus.store;
   assign bus.mm_stall     = w_stall;
   assign bus.mm_load      = w_load;
   assign bus.mm_halt      = (r_state == HALTED);
   assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_mm_access_unit.sv
// Directed bench for mm_access_unit: loads, LL/SC with snoops, halt, flush,
// counter saturation and asynchronous reset.
module tb_mm_access_unit;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mm_access_if #(.CNT_W(16)) bus ();

   mm_access_unit #(.CNT_W(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.en = 1'b0; bus.flush = 1'b0; bus.dRENi = 1'b0; bus.dWENi = 1'b0;
      bus.datomic = 1'b0; bus.halt = 1'b0; bus.ALUOut = 32'h0; bus.store = 32'h0;
      bus.dhit = 1'b0; bus.dmemload = 32'h0; bus.snoop_inv = 1'b0; bus.snoop_addr = 32'h0;
   endtask

   // Atomic op that hits at once while the pipeline advances.
   task automatic atomic_op(input logic is_ll, input logic [31:0] addr, input logic hit);
      idle();
      bus.dRENi = is_ll; bus.dWENi = ~is_ll; bus.datomic = 1'b1;
      bus.ALUOut = addr; bus.dhit = hit; bus.en = 1'b1;
   endtask

   // The hazard unit never advances the pipeline over a stalled access.
   always @(negedge CLK) begin
      if (!RST) check("no_en_in_stall", {31'b0, bus.en & bus.mm_stall}, 32'h0);
   end

   initial begin
      idle();
      bus.dRENi = 1'b1;
      #2;
      check("rst_ren", {31'b0, bus.dmemREN}, 32'h0);
      check("rst_stall", {31'b0, bus.mm_stall}, 32'h0);
      check("rst_cnt", {16'h0, bus.stall_cycles}, 32'h0);
      check("rst_halt", {31'b0, bus.mm_halt}, 32'h0);
      tick();
      RST = 1'b0;
      idle();
      $display("txn reset done");

      // Load 0x100, dhit on the third cycle, en held low.
      bus.dRENi = 1'b1; bus.ALUOut = 32'h100;
      @(negedge CLK);
      check("ld_c1_ren", {31'b0, bus.dmemREN}, 32'h1);
      check("ld_c1_stall", {31'b0, bus.mm_stall}, 32'h1);
      check("ld_addr", bus.dmemaddr, 32'h100);
      tick();
      @(negedge CLK);
      check("ld_c2_stall", {31'b0, bus.mm_stall}, 32'h1);
      tick();
      bus.dhit = 1'b1; bus.dmemload = 32'hDEADBEEF;
      @(negedge CLK);
      check("ld_c3_ren", {31'b0, bus.dmemREN}, 32'h1);
      check("ld_c3_stall", {31'b0, bus.mm_stall}, 32'h0);
      check("ld_c3_load", bus.mm_load, 32'hDEADBEEF);
      tick();
      bus.dhit = 1'b0; bus.dmemload = 32'h0;
      @(negedge CLK);
      check("ld_done_ren", {31'b0, bus.dmemREN}, 32'h0);
      check("ld_done_load", bus.mm_load, 32'hDEADBEEF);
      check("ld_cnt", {16'h0, bus.stall_cycles}, 32'h2);
      check("ld_state_done", {30'h0, dut.r_state}, {30'h0, DONE});
      tick();
      bus.en = 1'b1;
      @(negedge CLK);
      check("ld_hold_load", bus.mm_load, 32'hDEADBEEF);
      tick();
      idle();
      @(negedge CLK);
      check("ld_state_active", {30'h0, dut.r_state}, {30'h0, ACTIVE});
      $display("txn load 0x100 done");

      // LL then SC to the same word succeeds and consumes the link.
      atomic_op(1'b1, 32'h200, 1'b1);
      @(negedge CLK);
      check("ll_ren", {31'b0, bus.dmemREN}, 32'h1);
      tick();
      atomic_op(1'b0, 32'h200, 1'b1);
      bus.store = 32'h5;
      @(negedge CLK);
      check("sc_wen", {31'b0, bus.dmemWEN}, 32'h1);
      check("sc_load", bus.mm_load, 32'h1);
      check("sc_store", bus.dmemstore, 32'h5);
      tick();
      idle();
      @(negedge CLK);
      check("sc_link_cleared", {31'b0, dut.u_link.r_link.valid}, 32'h0);
      $display("txn ll/sc 0x200 done");

      // Snoop on the linked word kills the SC.
      atomic_op(1'b1, 32'h200, 1'b1);
      tick();
      idle();
      bus.en = 1'b1; bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h200;
      tick();
      atomic_op(1'b0, 32'h200, 1'b0);
      @(negedge CLK);
      check("snp_sc_wen", {31'b0, bus.dmemWEN}, 32'h0);
      check("snp_sc_load", bus.mm_load, 32'h0);
      check("snp_sc_stall", {31'b0, bus.mm_stall}, 32'h0);
      tick();
      $display("txn snoop 0x200 kills sc done");

      // Snoop on a neighbouring word leaves the link alone.
      atomic_op(1'b1, 32'h200, 1'b1);
      tick();
      idle();
      bus.en = 1'b1; bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h204;
      tick();
      atomic_op(1'b0, 32'h200, 1'b1);
      @(negedge CLK);
      check("nbr_sc_wen", {31'b0, bus.dmemWEN}, 32'h1);
      check("nbr_sc_load", bus.mm_load, 32'h1);
      tick();
      $display("txn snoop 0x204 sc ok done");

      // Snoop in the same cycle as the LL completes leaves no link.
      atomic_op(1'b1, 32'h300, 1'b1);
      bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h300;
      tick();
      atomic_op(1'b0, 32'h300, 1'b0);
      @(negedge CLK);
      check("llsnp_valid", {31'b0, dut.u_link.r_link.valid}, 32'h0);
      check("llsnp_sc_load", bus.mm_load, 32'h0);
      check("llsnp_sc_wen", {31'b0, bus.dmemWEN}, 32'h0);
      tick();
      $display("txn ll+snoop 0x300 done");

      // SC concurrent with a matching snoop still succeeds.
      atomic_op(1'b1, 32'h400, 1'b1);
      tick();
      atomic_op(1'b0, 32'h400, 1'b1);
      bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h400;
      @(negedge CLK);
      check("scsnp_load", bus.mm_load, 32'h1);
      check("scsnp_wen", {31'b0, bus.dmemWEN}, 32'h1);
      tick();
      $display("txn sc+snoop 0x400 done");

      // A plain store to the linked word breaks the link.
      atomic_op(1'b1, 32'h500, 1'b1);
      tick();
      idle();
      bus.dWENi = 1'b1; bus.ALUOut = 32'h500; bus.dhit = 1'b1; bus.en = 1'b1;
      tick();
      atomic_op(1'b0, 32'h500, 1'b0);
      @(negedge CLK);
      check("st_sc_load", bus.mm_load, 32'h0);
      tick();
      $display("txn store breaks link 0x500 done");

      // Flushed op issues nothing.
      idle();
      bus.dRENi = 1'b1; bus.flush = 1'b1; bus.en = 1'b1;
      @(negedge CLK);
      check("flush_ren", {31'b0, bus.dmemREN}, 32'h0);
      check("flush_stall", {31'b0, bus.mm_stall}, 32'h0);
      tick();
      $display("txn flush done");

      // Halt with no access, then HALTED blocks requests until reset.
      idle();
      bus.halt = 1'b1; bus.en = 1'b1;
      @(negedge CLK);
      check("halt_pre", {31'b0, bus.mm_halt}, 32'h0);
      tick();
      idle();
      bus.dRENi = 1'b1;
      @(negedge CLK);
      check("halt_set", {31'b0, bus.mm_halt}, 32'h1);
      check("halt_ren", {31'b0, bus.dmemREN}, 32'h0);
      check("halt_stall", {31'b0, bus.mm_stall}, 32'h0);
      RST = 1'b1;
      #1;
      check("halt_rst", {31'b0, bus.mm_halt}, 32'h0);
      tick();
      RST = 1'b0;
      idle();
      $display("txn halt done");

      // Long stall saturates the counter; async reset clears it at once.
      bus.dRENi = 1'b1; bus.ALUOut = 32'h600;
      repeat (70000) tick();
      @(negedge CLK);
      check("sat_cnt", {16'h0, bus.stall_cycles}, 32'hFFFF);
      check("sat_ren", {31'b0, bus.dmemREN}, 32'h1);
      #2;
      RST = 1'b1;
      #1;
      check("arst_cnt", {16'h0, bus.stall_cycles}, 32'h0);
      check("arst_ren", {31'b0, bus.dmemREN}, 32'h0);
      check("arst_stall", {31'b0, bus.mm_stall}, 32'h0);
      tick();
      RST = 1'b0;
      idle();
      $display("txn saturation and async reset done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
